// File: rtl/d_ff_pipe_if.sv
// Handshake-free data/valid bundle for the d_ff_pipe register chain.
// The master drives stimulus and control; the slave (the pipe) returns last-stage state.
interface d_ff_pipe_if #(
    parameter int WIDTH  = 3,
    parameter int STAGES = 2
);
    localparam int CW = $clog2(STAGES + 1);

    logic             set_n;
    logic             en;
    logic             d_in_vld;
    logic [WIDTH-1:0] d_in;
    logic [WIDTH-1:0] d_out;
    logic             d_out_vld;
    logic             d_chg;
    logic [CW-1:0]    fill_cnt;

    modport master (
        output set_n, en, d_in_vld, d_in,
        input  d_out, d_out_vld, d_chg, fill_cnt
    );

    modport slave (
        input  set_n, en, d_in_vld, d_in,
        output d_out, d_out_vld, d_chg, fill_cnt
    );
endinterface

// File: rtl/d_ff_pipe.sv
// Parametrised flop pipeline carrying {valid, data} per stage, with sync preload,
// stall, occupancy count and a registered change-detect pulse on the last stage.
module d_ff_pipe #(
    parameter int               WIDTH   = 3,
    parameter int               STAGES  = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter logic [WIDTH-1:0] SET_VAL = '1
) (
    input logic        clk,
    input logic        rst_n,
    d_ff_pipe_if.slave pipe
);
    localparam int CW = $clog2(STAGES + 1);

    // Each entry is {valid, data}; valid sits in the MSB.
    logic [WIDTH:0]   stage_reg   [STAGES];
    logic [WIDTH:0]   stage_shift [STAGES];
    logic [CW-1:0]    fill_cnt_reg;
    logic [CW-1:0]    fill_cnt_next;
    logic             d_chg_reg;
    logic             d_chg_next;
    logic [WIDTH:0]   last_in;
    logic [WIDTH:0]   last_cur;

    assign stage_shift[0] = {pipe.d_in_vld, pipe.d_in};

    generate
        for (genvar gi = 1; gi < STAGES; gi++) begin : g_shift
            assign stage_shift[gi] = stage_reg[gi-1];
        end
    endgenerate

    // The entry about to land in the last stage; for a single stage this is d_in itself.
    assign last_in  = stage_shift[STAGES-1];
    assign last_cur = stage_reg[STAGES-1];

    always_comb begin
        fill_cnt_next = fill_cnt_reg + CW'(pipe.d_in_vld) - CW'(last_cur[WIDTH]);
        d_chg_next    = last_in[WIDTH] && (last_in[WIDTH-1:0] != last_cur[WIDTH-1:0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_reg[k] <= {1'b0, RST_VAL};
            end
            fill_cnt_reg <= '0;
            d_chg_reg    <= 1'b0;
        end else if (!pipe.set_n) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_reg[k] <= {1'b1, SET_VAL};
            end
            fill_cnt_reg <= CW'(STAGES);
            d_chg_reg    <= 1'b0;
        end else if (pipe.en) begin
            stage_reg    <= stage_shift;
            fill_cnt_reg <= fill_cnt_next;
            d_chg_reg    <= d_chg_next;
        end else begin
            d_chg_reg    <= 1'b0;
        end
    end

    assign pipe.d_out     = last_cur[WIDTH-1:0];
    assign pipe.d_out_vld = last_cur[WIDTH];
    assign pipe.d_chg     = d_chg_reg;
    assign pipe.fill_cnt  = fill_cnt_reg;
endmodule

// File: tb/tb_d_ff_pipe.sv
// Scoreboard bench: three pipe configurations share one stimulus stream and are
// compared each cycle against a list-of-entries model of the pipeline.
module tb_d_ff_pipe;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       set_n;
    logic       en;
    logic       vld;
    logic [7:0] din;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    d_ff_pipe_if #(.WIDTH(3), .STAGES(2)) if0 ();
    d_ff_pipe_if #(.WIDTH(3), .STAGES(1)) if1 ();
    d_ff_pipe_if #(.WIDTH(8), .STAGES(5)) if2 ();

    assign if0.set_n = set_n; assign if0.en = en; assign if0.d_in_vld = vld; assign if0.d_in = din[2:0];
    assign if1.set_n = set_n; assign if1.en = en; assign if1.d_in_vld = vld; assign if1.d_in = din[2:0];
    assign if2.set_n = set_n; assign if2.en = en; assign if2.d_in_vld = vld; assign if2.d_in = din;

    d_ff_pipe #(.WIDTH(3), .STAGES(2)) u0 (.clk(clk), .rst_n(rst_n), .pipe(if0));
    d_ff_pipe #(.WIDTH(3), .STAGES(1)) u1 (.clk(clk), .rst_n(rst_n), .pipe(if1));
    d_ff_pipe #(.WIDTH(8), .STAGES(5)) u2 (.clk(clk), .rst_n(rst_n), .pipe(if2));

    logic [7:0] act_d [3];
    logic       act_v [3];
    logic       act_c [3];
    logic [2:0] act_f [3];

    always_comb begin
        act_d[0] = {5'b0, if0.d_out}; act_v[0] = if0.d_out_vld; act_c[0] = if0.d_chg; act_f[0] = {1'b0, if0.fill_cnt};
        act_d[1] = {5'b0, if1.d_out}; act_v[1] = if1.d_out_vld; act_c[1] = if1.d_chg; act_f[1] = {2'b0, if1.fill_cnt};
        act_d[2] = if2.d_out;         act_v[2] = if2.d_out_vld; act_c[2] = if2.d_chg; act_f[2] = if2.fill_cnt;
    end

    function automatic int depth(int i);
        return (i == 0) ? 2 : (i == 1) ? 1 : 5;
    endfunction

    function automatic logic [7:0] mask(int i);
        return (i == 2) ? 8'hFF : 8'h07;
    endfunction

    // Model: md/mv[i][0] is the newest entry, [depth-1] is what d_out shows.
    logic [7:0] md   [3][5];
    logic       mv   [3][5];
    logic       mchg [3];

    typedef struct packed {
        logic [7:0] d;
        logic       v;
        logic       c;
        logic [2:0] f;
    } exp_t;

    exp_t eq [3][$];

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 5; k++) begin
                md[i][k] = 8'h00;
                mv[i][k] = 1'b0;
            end
            mchg[i] = 1'b0;
        end
    endtask

    task automatic model_edge(input logic sn, input logic e, input logic v, input logic [7:0] d);
        for (int i = 0; i < 3; i++) begin
            int s = depth(i);
            int cnt = 0;
            exp_t x;
            if (!sn) begin
                for (int k = 0; k < s; k++) begin
                    md[i][k] = mask(i);
                    mv[i][k] = 1'b1;
                end
                mchg[i] = 1'b0;
            end else if (e) begin
                logic [7:0] old_out;
                old_out = md[i][s-1];
                for (int k = s - 1; k > 0; k--) begin
                    md[i][k] = md[i][k-1];
                    mv[i][k] = mv[i][k-1];
                end
                md[i][0] = d & mask(i);
                mv[i][0] = v;
                mchg[i]  = mv[i][s-1] && (md[i][s-1] != old_out);
            end else begin
                mchg[i] = 1'b0;
            end
            for (int k = 0; k < s; k++) cnt += int'(mv[i][k]);
            x.d = md[i][s-1];
            x.v = mv[i][s-1];
            x.c = mchg[i];
            x.f = 3'(cnt);
            eq[i].push_back(x);
        end
    endtask

    // Called just after a falling edge; the transaction lands on the next rising edge.
    task automatic step(input logic sn, input logic e, input logic v, input logic [7:0] d);
        set_n = sn; en = e; vld = v; din = d;
        model_edge(sn, e, v, d);
        $display("txn t=%0t set_n=%0b en=%0b vld=%0b d_in=%02h", $time, sn, e, v, d);
        @(negedge clk);
    endtask

    // Asynchronous reset pulse between clock edges, with set_n also low.
    task automatic do_reset();
        rst_n = 1'b0;
        set_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("u%0d rst d_out", i), int'(act_d[i]), 0);
            chk($sformatf("u%0d rst d_out_vld", i), int'(act_v[i]), 0);
            chk($sformatf("u%0d rst d_chg", i), int'(act_c[i]), 0);
            chk($sformatf("u%0d rst fill_cnt", i), int'(act_f[i]), 0);
        end
        #1;
        rst_n = 1'b1;
        set_n = 1'b1;
        model_reset();
        $display("txn t=%0t async reset", $time);
    endtask

    always begin
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            if (eq[i].size() > 0) begin
                exp_t x;
                x = eq[i].pop_front();
                chk($sformatf("u%0d d_out", i), int'(act_d[i]), int'(x.d));
                chk($sformatf("u%0d d_out_vld", i), int'(act_v[i]), int'(x.v));
                chk($sformatf("u%0d d_chg", i), int'(act_c[i]), int'(x.c));
                chk($sformatf("u%0d fill_cnt", i), int'(act_f[i]), int'(x.f));
            end
        end
    end

    initial begin
        rst_n = 1'b0; set_n = 1'b1; en = 1'b0; vld = 1'b0; din = 8'h00;
        model_reset();
        @(negedge clk);
        do_reset();

        // Latency: one valid 5 followed by bubbles
        step(1, 1, 1, 8'h05);
        step(1, 1, 0, 8'h00);
        step(1, 1, 0, 8'h00);

        // Stall with 3,5 in flight, then resume
        step(1, 1, 1, 8'h03);
        step(1, 1, 1, 8'h05);
        for (int k = 0; k < 4; k++) step(1, 0, 1, 8'h07);
        step(1, 1, 0, 8'h00);
        step(1, 1, 0, 8'h00);

        // Sync set overrides en, then reset mid-stream with set_n also low
        step(0, 1, 1, 8'h02);
        step(1, 0, 0, 8'h00);
        do_reset();

        // Change detect: 4,4,6 valid then invalid entries
        step(1, 1, 1, 8'h04);
        step(1, 1, 1, 8'h04);
        step(1, 1, 1, 8'h06);
        for (int k = 0; k < 6; k++) step(1, 1, 0, 8'h06);

        // Randomised run with occasional async resets
        for (int n = 0; n < 400; n++) begin
            if (n % 97 == 96) do_reset();
            step(logic'($urandom_range(0, 15) != 0), logic'($urandom_range(0, 3) != 0),
                 logic'($urandom_range(0, 1)), 8'($urandom));
        end

        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) chk($sformatf("u%0d scoreboard drained", i), eq[i].size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
